// File: rtl/uart_packet_tx_arbiter_if.sv
// Packet-stream byte type and the requester/transmitter bundle around the UART packet TX arbiter.
// Valid/ready: a byte moves on a clock edge exactly when Valid && ready are both high in that cycle.
package uart_packet_pkg;
    typedef struct packed {
        logic [3:0] Source;
        logic [3:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;
endpackage

interface uart_packet_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import uart_packet_pkg::*;

    UART_PACKET [NUM_REQ-1:0] ipStream;
    logic [NUM_REQ-1:0]       opReady;
    UART_PACKET               opTxStream;
    logic                     ipTxReady;

    // master: requesters plus transmitter side; slave: the arbiter.
    modport master (output ipStream, output ipTxReady, input opReady, input opTxStream);
    modport slave  (input ipStream, input ipTxReady, output opReady, output opTxStream);
endinterface

// File: rtl/uart_packet_tx_arbiter.sv
// Round-robin packet arbiter for the shared UART packet transmitter: grants one requester
// from SoP to EoP, drops stray non-SoP bytes while idle, and aborts stalled packets.
module uart_packet_tx_arbiter
    import uart_packet_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ipClk,
    input  logic                    reset,
    uart_packet_tx_arbiter_if.slave bus,
    output logic [1:0]              opGrant,
    output logic                    opBusy,
    output logic                    opTimeout,
    output logic [7:0]              opDropCount,
    output logic                    opDbgLocked
);
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

    state_t            state;
    logic [1:0]        rrPtr;
    logic [WD_W-1:0]   wdCount;

    UART_PACKET         grantStream;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] dropping;
    logic               selFound;
    logic [1:0]         selIdx;
    logic [2:0]         scan;
    logic [2:0]         dropNum;
    logic [8:0]         dropTotal;
    logic [7:0]         dropNext;
    logic [1:0]         nextPtr;
    logic               xfer;
    logic               abort;

    always_comb begin
        grantStream = '0;
        eligible    = '0;
        dropping    = '0;
        dropNum     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.ipStream[i].Valid && bus.ipStream[i].SoP;
            dropping[i] = bus.ipStream[i].Valid && !bus.ipStream[i].SoP;
            dropNum     = dropNum + 3'(dropping[i]);
            if (opGrant == 2'(i)) grantStream = bus.ipStream[i];
        end
    end

    // Scan from the highest offset down so the requester nearest the pointer wins.
    always_comb begin
        selFound = 1'b0;
        selIdx   = '0;
        scan     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, rrPtr} + 3'(k);
            if (scan >= 3'(NUM_REQ)) scan = scan - 3'(NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (scan == 3'(j) && eligible[j]) begin
                    selFound = 1'b1;
                    selIdx   = 2'(j);
                end
            end
        end
    end

    always_comb begin
        dropTotal = {1'b0, opDropCount} + 9'(dropNum);
        dropNext  = (dropTotal > 9'd255) ? 8'd255 : dropTotal[7:0];
        nextPtr   = (opGrant == 2'(NUM_REQ - 1)) ? 2'd0 : opGrant + 2'd1;
        xfer      = grantStream.Valid && bus.ipTxReady;
        abort     = WD_EN && !grantStream.Valid && (wdCount == WD_LAST);
    end

    // Pass-through and backpressure are combinational while locked; idle readiness only drains strays.
    always_comb begin
        bus.opReady    = '0;
        bus.opTxStream = '0;
        if (state == LOCKED) begin
            bus.opTxStream = grantStream;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (opGrant == 2'(i)) bus.opReady[i] = bus.ipTxReady;
            end
        end else if (!reset) begin
            bus.opReady = dropping;
        end
    end

    assign opDbgLocked = (state == LOCKED);

    always_ff @(posedge ipClk) begin
        if (reset) begin
            state       <= IDLE;
            rrPtr       <= '0;
            opGrant     <= '0;
            opBusy      <= 1'b0;
            opTimeout   <= 1'b0;
            opDropCount <= '0;
            wdCount     <= '0;
        end else begin
            opTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    opDropCount <= dropNext;
                    if (selFound) begin
                        opGrant <= selIdx;
                        opBusy  <= 1'b1;
                        wdCount <= '0;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        wdCount <= '0;
                        if (grantStream.EoP) begin
                            state  <= IDLE;
                            opBusy <= 1'b0;
                            rrPtr  <= nextPtr;
                        end
                    end else if (!grantStream.Valid) begin
                        if (abort) begin
                            state     <= IDLE;
                            opBusy    <= 1'b0;
                            opTimeout <= 1'b1;
                            rrPtr     <= nextPtr;
                        end else begin
                            wdCount <= wdCount + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_packet_tx_arbiter.sv
// Bench for uart_packet_tx_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a packet-level behavioural model.
module tb_uart_packet_tx_arbiter;
    import uart_packet_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 8;

    logic       ipClk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] opGrant;
    logic       opBusy;
    logic       opTimeout;
    logic [7:0] opDropCount;
    logic       opDbgLocked;

    uart_packet_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_packet_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .ipClk       (ipClk),
        .reset       (reset),
        .bus         (bus.slave),
        .opGrant     (opGrant),
        .opBusy      (opBusy),
        .opTimeout   (opTimeout),
        .opDropCount (opDropCount),
        .opDbgLocked (opDbgLocked)
    );

    // ---------------- clock/reset ----------------
    always #5 ipClk = ~ipClk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- requester drivers ----------------
    typedef struct {
        logic [7:0] data;
        logic [7:0] len;
        logic [3:0] dst;
        logic       sop;
        logic       eop;
        logic       gap;
    } rec_t;

    rec_t       pend [N][$];
    logic [N-1:0] presented = '0;
    logic [N-1:0] consumed  = '0;
    int         txMode = 0;
    int         stepCount = 0;
    bit         chkOn = 0;

    task automatic push_rec(input int r, input logic [7:0] d, input logic [7:0] len,
                            input logic sop, input logic eop, input logic gap);
        rec_t x;
        x.data = d; x.len = len; x.dst = 4'($urandom_range(15));
        x.sop = sop; x.eop = eop; x.gap = gap;
        pend[r].push_back(x);
    endtask

    task automatic add_packet(input int r, input int len, input logic [7:0] base, input int gapPct);
        for (int b = 0; b < len; b++) begin
            if (b > 0 && gapPct > 0 && $urandom_range(99) < gapPct) push_rec(r, 8'h00, 8'(len), 0, 0, 1);
            push_rec(r, base + 8'(b), 8'(len), b == 0, b == len - 1, 0);
        end
    endtask

    task automatic add_gaps(input int r, input int n);
        for (int b = 0; b < n; b++) push_rec(r, 8'h00, 8'h00, 0, 0, 1);
    endtask

    task automatic add_junk(input int r, input int n, input logic [7:0] base);
        for (int b = 0; b < n; b++) push_rec(r, base + 8'(b), 8'h00, 0, 0, 0);
    endtask

    task automatic drive_inputs();
        UART_PACKET p;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < N; i++) begin
            if (presented[i] && pend[i].size() > 0 && (pend[i][0].gap || consumed[i]))
                void'(pend[i].pop_front());
            p = '0;
            presented[i] = 1'b0;
            if (pend[i].size() > 0) begin
                presented[i] = 1'b1;
                if (!pend[i][0].gap) begin
                    p.Valid       = 1'b1;
                    p.SoP         = pend[i][0].sop;
                    p.EoP         = pend[i][0].eop;
                    p.Data        = pend[i][0].data;
                    p.Length      = pend[i][0].len;
                    p.Destination = pend[i][0].dst;
                    p.Source      = 4'(i);
                end
            end
            bus.ipStream[i] = p;
        end
        case (txMode)
            0:       bus.ipTxReady = 1'b1;
            1:       bus.ipTxReady = ($urandom_range(3) != 0);
            default: bus.ipTxReady = pat[3 - (stepCount % 4)];
        endcase
    endtask

    task automatic step();
        @(posedge ipClk);
        #1;
        stepCount++;
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) pend[i].delete();
        presented = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        step();
        reset = 1'b0;
        step();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (pend[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- monitor logs ----------------
    int         cyc = 0;
    int         txCount = 0;
    int         busyCycles = 0;
    int         txValidCycles = 0;
    int         toCount = 0;
    int         toCyc = 0;
    logic       prevBusy = 1'b0;
    int         grantLog [$];
    int         riseCyc [$];
    logic [7:0] txLog [$];

    task automatic clear_mon();
        txCount = 0; busyCycles = 0; txValidCycles = 0; toCount = 0; toCyc = 0;
        grantLog.delete(); riseCyc.delete(); txLog.delete();
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    bit         mLocked = 0;
    bit         mTo = 0;
    int         mOwner = 0;
    int         mPtr = 0;
    int         mIdle = 0;
    int         mDrop = 0;
    logic [7:0] exp_q [$];
    UART_PACKET eTx;
    UART_PACKET g;
    logic [N-1:0] eRdy;
    bit         found;
    int         r;

    always @(negedge ipClk) begin
        cyc++;
        for (int i = 0; i < N; i++) consumed[i] = bus.ipStream[i].Valid && bus.opReady[i];
        if (chkOn) begin
            eTx  = '0;
            eRdy = '0;
            if (mLocked) begin
                eTx          = bus.ipStream[mOwner];
                eRdy[mOwner] = bus.ipTxReady;
            end else if (!reset) begin
                for (int i = 0; i < N; i++) eRdy[i] = bus.ipStream[i].Valid && !bus.ipStream[i].SoP;
            end
            check("txStream", 32'(bus.opTxStream), 32'(eTx));
            check("ready", 32'(bus.opReady), 32'(eRdy));
            check("grant", 32'(opGrant), 32'(mOwner));
            check("busy", 32'(opBusy), 32'(mLocked));
            check("timeout", 32'(opTimeout), 32'(mTo));
            check("dropCount", 32'(opDropCount), 32'(mDrop));

            if (mLocked && bus.ipStream[mOwner].Valid && bus.opReady[mOwner])
                exp_q.push_back(bus.ipStream[mOwner].Data);
            if (bus.opTxStream.Valid && bus.ipTxReady) begin
                if (exp_q.size() == 0) check("txUnexpected", 32'(bus.opTxStream.Data), 32'hFFFF_FFFF);
                else check("txData", 32'(bus.opTxStream.Data), 32'(exp_q.pop_front()));
                txCount++;
                txLog.push_back(bus.opTxStream.Data);
            end
            if (opBusy && !prevBusy) begin
                grantLog.push_back(int'(opGrant));
                riseCyc.push_back(cyc);
            end
            if (opTimeout) begin toCount++; toCyc = cyc; end
            if (opBusy) busyCycles++;
            if (bus.opTxStream.Valid) txValidCycles++;
            prevBusy = opBusy;

            // Advance the model across the coming edge.
            if (reset) begin
                mLocked = 0; mTo = 0; mOwner = 0; mPtr = 0; mIdle = 0; mDrop = 0;
                exp_q.delete();
            end else begin
                mTo = 0;
                if (mLocked) begin
                    g = bus.ipStream[mOwner];
                    if (g.Valid && bus.ipTxReady) begin
                        mIdle = 0;
                        if (g.EoP) begin mLocked = 0; mPtr = (mOwner + 1) % N; end
                    end else if (!g.Valid) begin
                        mIdle++;
                        if (mIdle == TMO) begin mLocked = 0; mTo = 1; mPtr = (mOwner + 1) % N; end
                    end
                end else begin
                    for (int i = 0; i < N; i++)
                        if (bus.ipStream[i].Valid && !bus.ipStream[i].SoP && mDrop < 255) mDrop++;
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        r = (mPtr + k) % N;
                        if (!found && bus.ipStream[r].Valid && bus.ipStream[r].SoP) begin
                            found = 1; mLocked = 1; mOwner = r; mIdle = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.ipTxReady = 1'b0;
        for (int i = 0; i < N; i++) bus.ipStream[i] = '0;
        @(posedge ipClk);
        #1;
        chkOn = 1;
        reset = 1'b0;
        step();

        // Reset state
        check("rst_busy", 32'(opBusy), 32'd0);
        check("rst_grant", 32'(opGrant), 32'd0);
        check("rst_drop", 32'(opDropCount), 32'd0);
        check("rst_tx", 32'(bus.opTxStream), 32'd0);

        // Single 4-byte packet from requester 0
        clear_mon();
        add_packet(0, 4, 8'h10, 0);
        run(10);
        check("single_txCount", 32'(txCount), 32'd4);
        check("single_busyCycles", 32'(busyCycles), 32'd4);
        check("single_grant", 32'(grantLog.size() == 1 ? grantLog[0] : -1), 32'd0);
        for (int b = 0; b < 4; b++)
            check("single_order", 32'(txLog.size() > b ? txLog[b] : 8'hEE), 32'(8'h10 + b));

        // Simultaneous SoP from 0 and 1, twice
        do_reset();
        clear_mon();
        add_packet(0, 2, 8'h20, 0);
        add_packet(1, 2, 8'h30, 0);
        run(12);
        add_packet(0, 2, 8'h24, 0);
        add_packet(1, 2, 8'h34, 0);
        run(12);
        check("rr_grants", 32'(grantLog.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check("rr_order", 32'(grantLog.size() > k ? grantLog[k] : -1), 32'(k % 2));
        check("rr_gap", 32'(riseCyc.size() > 1 ? riseCyc[1] - riseCyc[0] : -1), 32'd3);

        // ipTxReady toggling 1,0,0,1 with requester 1 waiting
        do_reset();
        clear_mon();
        txMode = 2;
        add_packet(0, 4, 8'h40, 0);
        add_packet(1, 2, 8'h50, 0);
        run(24);
        txMode = 0;
        check("toggle_txCount", 32'(txCount), 32'd6);
        for (int b = 0; b < 6; b++)
            check("toggle_order", 32'(txLog.size() > b ? txLog[b] : 8'hEE),
                  32'(b < 4 ? 8'h40 + b : 8'h50 + b - 4));

        // Stray bytes without SoP while idle
        do_reset();
        clear_mon();
        add_junk(1, 3, 8'h60);
        run(6);
        check("drop_count", 32'(opDropCount), 32'd3);
        check("drop_txValid", 32'(txValidCycles), 32'd0);

        // Watchdog abort with requester 1 pending
        do_reset();
        clear_mon();
        push_rec(0, 8'h70, 8'd4, 1, 0, 0);
        add_gaps(0, 12);
        add_packet(1, 2, 8'h80, 0);
        run(30);
        check("wd_pulses", 32'(toCount), 32'd1);
        check("wd_grants", 32'(grantLog.size()), 32'd2);
        check("wd_first", 32'(grantLog.size() > 0 ? grantLog[0] : -1), 32'd0);
        check("wd_second", 32'(grantLog.size() > 1 ? grantLog[1] : -1), 32'd1);
        check("wd_latency", 32'(riseCyc.size() > 0 ? toCyc - riseCyc[0] : -1), 32'd9);
        check("wd_regrant", 32'(riseCyc.size() > 1 ? riseCyc[1] - toCyc : -1), 32'd1);
        check("wd_txCount", 32'(txCount), 32'd3);

        // Reset while byte 2 of a 4-byte packet is on the transmitter
        do_reset();
        clear_mon();
        add_packet(0, 4, 8'h90, 0);
        for (int t = 0; t < 20 && txCount != 2; t++) step();
        check("midrst_reach_byte2", 32'(txCount), 32'd2);
        reset = 1'b1;
        step();
        flush();
        check("midrst_busy", 32'(opBusy), 32'd0);
        check("midrst_grant", 32'(opGrant), 32'd0);
        check("midrst_timeout", 32'(opTimeout), 32'd0);
        check("midrst_drop", 32'(opDropCount), 32'd0);
        check("midrst_tx", 32'(bus.opTxStream), 32'd0);
        check("midrst_ready", 32'(bus.opReady), 32'd0);
        reset = 1'b0;
        step();
        clear_mon();
        add_packet(1, 2, 8'hA0, 0);
        run(8);
        check("midrst_regrant", 32'(grantLog.size() == 1 ? grantLog[0] : -1), 32'd1);
        check("midrst_txCount", 32'(txCount), 32'd2);
        check("midrst_noPulse", 32'(toCount), 32'd0);

        // Random traffic
        do_reset();
        txMode = 1;
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() == 0 && $urandom_range(9) == 0) begin
                    int kind;
                    kind = $urandom_range(99);
                    if (kind < 85) begin
                        add_packet(i, $urandom_range(6, 1), 8'($urandom_range(255)), 20);
                    end else if (kind < 90) begin
                        push_rec(i, 8'($urandom_range(255)), 8'd3, 1, 0, 0);
                        add_gaps(i, 10);
                        add_junk(i, 2, 8'($urandom_range(255)));
                    end else begin
                        add_junk(i, $urandom_range(2, 1), 8'($urandom_range(255)));
                    end
                end
            end
            step();
        end
        txMode = 0;
        for (int t = 0; t < 1000 && !(all_empty() && !opBusy); t++) step();
        check("drain_done", 32'(all_empty() && !opBusy), 32'd1);
        run(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
